// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD controller: HD44780 command
// bytes, the top-level and bus-transfer state encodings, the DDRAM
// row-base lookup, and small width helpers.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_FUNC_8B1L = 8'h30;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] CHAR_SPACE    = 8'h20;

  // ST_CLRW is the post-clear execution wait; ST_FILL blanks the buffer
  // on a runtime clear request.
  typedef enum logic [3:0] {
    ST_PWR, ST_FUNC, ST_DISP, ST_ENTRY, ST_CLEAR, ST_CLRW, ST_ROW, ST_CHAR, ST_FILL
  } lcd_state_e;

  typedef enum logic [1:0] {XF_IDLE, XF_SETUP, XF_HIGH, XF_GAP} xfer_ph_e;

  // DDRAM address of column 0 for each row; rows 2/3 continue rows 0/1.
  function automatic logic [7:0] row_base(input int unsigned r, input int unsigned cols);
    case (r)
      0:       return 8'h00;
      1:       return 8'h40;
      2:       return 8'(cols);
      default: return 8'(32'h40 + cols);
    endcase
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed to count 0..v-1, never less than one.
  function automatic int unsigned width_of(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// One LCD bus transfer: a setup cycle with RS/DATA driven and E low,
// E_HIGH cycles of E high, then GAP idle cycles. done_o is high in the
// final GAP cycle; a start_i in that cycle chains the next transfer with
// no bubble, so the period is exactly 1+E_HIGH+GAP.
// Ports: clk_i, reset_i (sync, active-high), start_i/rs_i/data_i request,
//        done_o, lcd_e_o/lcd_rs_o/lcd_data_o registered bus outputs.
module lcd_bus_xfer import lcd_pkg::*; #(
  parameter int unsigned E_HIGH = 12,
  parameter int unsigned GAP    = 2000,
  parameter int unsigned CNT_W  = 11
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o
);

  localparam logic [CNT_W-1:0] E_LAST = CNT_W'(E_HIGH - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP - 1);

  xfer_ph_e         ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d, rs_q, rs_d;
  logic [7:0]       data_q, data_d;

  always_comb begin
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    e_d    = e_q;
    rs_d   = rs_q;
    data_d = data_q;
    done_o = (ph_q == XF_GAP) && (cnt_q == G_LAST);
    unique case (ph_q)
      XF_SETUP: begin ph_d = XF_HIGH; e_d = 1'b1; cnt_d = '0; end
      XF_HIGH:
        if (cnt_q == E_LAST) begin e_d = 1'b0; ph_d = XF_GAP; cnt_d = '0; end
        else cnt_d = cnt_q + 1'b1;
      XF_GAP:
        if (done_o) ph_d = XF_IDLE;
        else        cnt_d = cnt_q + 1'b1;
      default: ;
    endcase
    // RS/DATA are captured only here, so they hold until the next setup.
    if (start_i && (ph_q == XF_IDLE || done_o)) begin
      ph_d   = XF_SETUP;
      rs_d   = rs_i;
      data_d = data_i;
      e_d    = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ph_q   <= XF_IDLE;
      cnt_q  <= '0;
      e_q    <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      e_q    <= e_d;
      rs_q   <= rs_d;
      data_q <= data_d;
    end
  end

  assign lcd_e_o    = e_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// ROWS x COLS character-LCD controller. Runs the HD44780 8-bit init
// sequence after reset, then refreshes every row forever from a local
// character buffer written by the client.
// Ports: clk_i, reset_i (sync, active-high); wr_en_i/wr_addr_i/wr_data_i
//        buffer write (index row*COLS+col); ready_o after init;
//        frame_done_o one-cycle pulse per refresh; lcd_e_o/lcd_rs_o/
//        lcd_rw_o/lcd_data_o LCD bus.
// Option LCD_CLEAR_EN: adds clr_req_i; a latched request blanks the buffer
//        and re-sends the clear command at the next frame boundary.
module lcd_text_ctrl import lcd_pkg::*; #(
  parameter int unsigned COLS     = 16,
  parameter int unsigned ROWS     = 2,
  parameter int unsigned E_HIGH   = 12,
  parameter int unsigned GAP      = 2000,
  parameter int unsigned PWR_WAIT = 750000,
  parameter int unsigned CLR_WAIT = 80000
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          wr_en_i,
  input  logic [$clog2(ROWS*COLS)-1:0]  wr_addr_i,
  input  logic [7:0]                    wr_data_i,
`ifdef LCD_CLEAR_EN
  input  logic                          clr_req_i,
`endif
  output logic                          ready_o,
  output logic                          frame_done_o,
  output logic                          lcd_e_o,
  output logic                          lcd_rs_o,
  output logic                          lcd_rw_o,
  output logic [7:0]                    lcd_data_o
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned AW    = $clog2(N);
  localparam int unsigned CNT_W = width_of(max4(PWR_WAIT, CLR_WAIT, GAP, E_HIGH));
  localparam int unsigned RW_W  = width_of(ROWS);
  localparam int unsigned CL_W  = width_of(COLS);

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_WAIT - 1);
  localparam logic [CNT_W-1:0] CLRW_LAST = CNT_W'(CLR_WAIT - 1);
  localparam logic [RW_W-1:0]  ROW_LAST  = RW_W'(ROWS - 1);
  localparam logic [CL_W-1:0]  COL_LAST  = CL_W'(COLS - 1);
  localparam logic [AW-1:0]    IDX_LAST  = AW'(N - 1);
  localparam logic [7:0]       FUNC_CMD  = (ROWS == 1) ? CMD_FUNC_8B1L : CMD_FUNC_8B2L;

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [RW_W-1:0]  row_q, row_d;
  logic [CL_W-1:0]  col_q, col_d;
  logic [AW-1:0]    idx_q, idx_d;     // next char to send, or fill pointer
  logic             ready_q, ready_d, fdone_q, fdone_d;
  logic             clr_pend_q, clr_pend_d, clr_req;
  logic [7:0]       mem_q [N];

  logic       x_start, x_rs, x_done, fill_we, wr_ok;
  logic [7:0] x_data;

`ifdef LCD_CLEAR_EN
  assign clr_req = clr_req_i;
`else
  assign clr_req = 1'b0;
`endif

  assign wr_ok = (32'(wr_addr_i) < N);

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    row_d      = row_q;
    col_d      = col_q;
    idx_d      = idx_q;
    ready_d    = ready_q;
    fdone_d    = 1'b0;
    clr_pend_d = clr_pend_q | clr_req;
    x_start    = 1'b0;
    x_rs       = 1'b0;
    x_data     = 8'h00;
    fill_we    = 1'b0;
    unique case (state_q)
      ST_PWR:
        if (wait_q == PWR_LAST) begin
          wait_d = '0; x_start = 1'b1; x_data = FUNC_CMD; state_d = ST_FUNC;
        end else wait_d = wait_q + 1'b1;
      ST_FUNC:  if (x_done) begin x_start = 1'b1; x_data = CMD_DISP_ON;   state_d = ST_DISP;  end
      ST_DISP:  if (x_done) begin x_start = 1'b1; x_data = CMD_ENTRY_INC; state_d = ST_ENTRY; end
      ST_ENTRY: if (x_done) begin x_start = 1'b1; x_data = CMD_CLEAR;     state_d = ST_CLEAR; end
      ST_CLEAR: if (x_done) begin wait_d = '0; state_d = ST_CLRW; end
      ST_CLRW:
        if (wait_q == CLRW_LAST) begin
          wait_d  = '0;
          ready_d = 1'b1;
          row_d   = '0;
          idx_d   = '0;
          x_start = 1'b1;
          x_data  = CMD_SET_DDRAM | row_base(0, COLS);
          state_d = ST_ROW;
        end else wait_d = wait_q + 1'b1;
      // The buffer byte is read in the cycle start is issued; a same-cycle
      // write lands after the read and shows up on the next frame.
      ST_ROW:
        if (x_done) begin
          x_start = 1'b1; x_rs = 1'b1; x_data = mem_q[idx_q];
          idx_d = idx_q + 1'b1; col_d = '0; state_d = ST_CHAR;
        end
      ST_CHAR:
        if (x_done) begin
          if (col_q != COL_LAST) begin
            x_start = 1'b1; x_rs = 1'b1; x_data = mem_q[idx_q];
            idx_d = idx_q + 1'b1; col_d = col_q + 1'b1;
          end else if (row_q != ROW_LAST) begin
            row_d   = row_q + 1'b1;
            x_start = 1'b1;
            x_data  = CMD_SET_DDRAM | row_base(32'(row_q) + 32'd1, COLS);
            state_d = ST_ROW;
          end else begin
            fdone_d = 1'b1;
            row_d   = '0;
            idx_d   = '0;
            if (clr_pend_q) begin
              clr_pend_d = clr_req;
              state_d    = ST_FILL;
            end else begin
              x_start = 1'b1;
              x_data  = CMD_SET_DDRAM | row_base(0, COLS);
              state_d = ST_ROW;
            end
          end
        end
      ST_FILL: begin
        fill_we = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d = '0; x_start = 1'b1; x_data = CMD_CLEAR; state_d = ST_CLEAR;
        end else idx_d = idx_q + 1'b1;
      end
      default: state_d = ST_PWR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_PWR;
      wait_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      fdone_q    <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      row_q      <= row_d;
      col_q      <= col_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      fdone_q    <= fdone_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  // Client writes are dropped while a clear is blanking the buffer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < N; i++) mem_q[i] <= CHAR_SPACE;
    end else if (fill_we) begin
      mem_q[idx_q] <= CHAR_SPACE;
    end else if (wr_en_i && wr_ok) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  lcd_bus_xfer #(.E_HIGH(E_HIGH), .GAP(GAP), .CNT_W(CNT_W)) u_xfer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (x_start),
    .rs_i      (x_rs),
    .data_i    (x_data),
    .done_o    (x_done),
    .lcd_e_o   (lcd_e_o),
    .lcd_rs_o  (lcd_rs_o),
    .lcd_data_o(lcd_data_o)
  );

  assign lcd_rw_o     = 1'b0;
  assign ready_o      = ready_q;
  assign frame_done_o = fdone_q;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
module tb_lcd_text_ctrl;
  localparam int COLS = 4, ROWS = 2, E_HIGH = 2, GAP = 3, PWR_WAIT = 10, CLR_WAIT = 5;
  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0, reset = 1'b1, wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = 8'h00;
`ifdef LCD_CLEAR_EN
  logic          clr_req = 1'b0;
`endif
  logic          ready, fdone, e, rs, rw;
  logic [7:0]    data;

  int         checks = 0, errors = 0;
  int         cyc = 0, rel = 0;
  logic [8:0] expq[$];
  logic [8:0] exp_v;
  logic [7:0] mbuf [N];
  logic       prev_e = 1'b0, mon_en = 1'b0, rdy_watch = 1'b0, rdy_drop = 1'b0;

  lcd_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .E_HIGH(E_HIGH), .GAP(GAP),
                  .PWR_WAIT(PWR_WAIT), .CLR_WAIT(CLR_WAIT)) dut (
    .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
`ifdef LCD_CLEAR_EN
    .clr_req_i(clr_req),
`endif
    .ready_o(ready), .frame_done_o(fdone), .lcd_e_o(e), .lcd_rs_o(rs),
    .lcd_rw_o(rw), .lcd_data_o(data));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every rising E pops the next expected {RS,DATA}.
  always @(negedge clk) begin
    if (mon_en && e === 1'b1 && prev_e === 1'b0) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got rs=%0b data=%02h, required no transfer", rs, data);
      end else begin
        exp_v = expq.pop_front();
        if ({rs, data} !== exp_v) begin
          errors++;
          $display("FAIL xfer: got rs=%0b data=%02h, required rs=%0b data=%02h",
                   rs, data, exp_v[8], exp_v[7:0]);
        end
      end
    end
    if (rdy_watch && ready !== 1'b1) rdy_drop <= 1'b1;
    prev_e <= e;
  end

  task automatic push_cmd(input logic [7:0] c);
    expq.push_back({1'b0, c});
  endtask

  task automatic push_frame();
    for (int r = 0; r < ROWS; r++) begin
      expq.push_back({1'b0, (r == 0) ? 8'h80 : 8'hC0});
      for (int c = 0; c < COLS; c++) expq.push_back({1'b1, mbuf[r*COLS+c]});
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Waits for FRAME_DONE; all expected transfers must have been seen by then.
  task automatic sync_frame(output int at);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (fdone !== 1'b1 && n < 400);
    at = cyc - rel;
    checks++;
    if (fdone !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_timeout: got no pulse in %0d cycles, required a pulse", n);
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL frame_drain: got %0d transfers outstanding, required 0", expq.size());
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({e, rs, rw, data, ready, fdone} !== 13'h0) begin
        errors++;
        $display("FAIL reset_outputs: got e=%b rs=%b rw=%b data=%02h ready=%b fd=%b, required all 0",
                 e, rs, rw, data, ready, fdone);
      end
    end
    for (int i = 0; i < N; i++) mbuf[i] = 8'h20;
    expq.delete();
    push_cmd(8'h38); push_cmd(8'h0C); push_cmd(8'h06); push_cmd(8'h01);
    push_frame();
    mon_en = 1'b1;
    reset  = 1'b0;
    rel    = cyc;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (ready !== 1'b1 || cyc - rel != 39) begin
      errors++;
      $display("FAIL ready_rise: got ready=%b at cycle %0d, required 1 at cycle 39", ready, cyc - rel);
    end
  endtask

  task automatic test_default_frame();
    int t, last;
    sync_frame(t);
    checks++;
    if (t != 99) begin
      errors++;
      $display("FAIL frame_done_first: got cycle %0d, required 99", t);
    end
    push_frame();
    last = t;
    sync_frame(t);
    checks++;
    if (t - last != 60) begin
      errors++;
      $display("FAIL frame_period: got %0d cycles, required 60", t - last);
    end
  endtask

  // With 8 cells the 3-bit address bus cannot encode an out-of-range index.
  task automatic test_writes();
    int t;
    mbuf[0] = 8'h41; mbuf[7] = 8'h5A;
    push_frame();
    wr(0, 8'h41);
    wr(7, 8'h5A);
    sync_frame(t);
  endtask

  task automatic test_collision();
    int t;
    push_frame();
    repeat (12) @(negedge clk);   // setup cycle of index 1
    checks++;
    if ({e, rs, data} !== {1'b0, 1'b1, 8'h20}) begin
      errors++;
      $display("FAIL collision_setup: got e=%b rs=%b data=%02h, required e=0 rs=1 data=20", e, rs, data);
    end
    wr(1, 8'h42);
    mbuf[1] = 8'h42;
    sync_frame(t);
    push_frame();
    sync_frame(t);
  endtask

  task automatic test_reset_mid();
    int t, n;
    push_frame();
    repeat (19) @(negedge clk);   // first E-high cycle of index 2
    checks++;
    if ({e, rs, data} !== {1'b1, 1'b1, mbuf[2]}) begin
      errors++;
      $display("FAIL mid_e_high: got e=%b rs=%b data=%02h, required e=1 rs=1 data=%02h", e, rs, data, mbuf[2]);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({e, rs, rw, data, ready, fdone} !== 13'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got e=%b rs=%b data=%02h ready=%b, required all 0", e, rs, data, ready);
    end
    mon_en = 1'b0;
    expq.delete();
    for (int i = 0; i < N; i++) mbuf[i] = 8'h20;
    push_cmd(8'h38); push_cmd(8'h0C); push_cmd(8'h06); push_cmd(8'h01);
    push_frame();
    @(negedge clk);
    mon_en = 1'b1;
    reset  = 1'b0;
    rel    = cyc;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (ready !== 1'b1 || cyc - rel != 39) begin
      errors++;
      $display("FAIL mid_ready_rise: got ready=%b at cycle %0d, required 1 at cycle 39", ready, cyc - rel);
    end
    sync_frame(t);
    checks++;
    if (t != 99) begin
      errors++;
      $display("FAIL mid_frame_done: got cycle %0d, required 99", t);
    end
  endtask

`ifdef LCD_CLEAR_EN
  task automatic test_clear();
    int t;
    mbuf[3] = 8'h55;
    push_frame();
    wr(3, 8'h55);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    rdy_watch = 1'b1;
    sync_frame(t);
    push_cmd(8'h01);
    for (int i = 0; i < N; i++) mbuf[i] = 8'h20;
    push_frame();
    sync_frame(t);
    rdy_watch = 1'b0;
    checks++;
    if (rdy_drop !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready: got ready drop=%b, required 0", rdy_drop);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_frame();
    test_writes();
    test_collision();
    test_reset_mid();
`ifdef LCD_CLEAR_EN
    test_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
